s3511_host: RTL and testbench

- Serial master for the S-3511A-style RTC three-wire bus. It is the other end of the RTC chip model: it drives chip-select, SCK and the SIO data line.
- Sends the command byte MSB-first, then transfers the command-specific number of data bytes LSB-first, either writing to the RTC or reading from it.
- Sits between the GBA cartridge GPIO logic (or a core-side controller) and the RTC chip logic.

---
 rtl/s3511_host.sv | 153 +++++++++++++++
 tb/tb_s3511_host.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s3511_host.sv
// Serial master for the S-3511A RTC three-wire bus: command byte MSB-first,
// then N data bytes LSB-first, written to or read from the RTC.
module s3511_host #(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  cmd,
  input  logic        rnw,
  input  logic [55:0] wdata,
  output logic [55:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        rtc_cs,
  output logic        rtc_sck,
  output logic        sio_out,
  output logic        sio_oe,
  input  logic        sio_in,
  output logic [2:0]  dbg_state
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_BIT_LO, S_BIT_HI, S_HOLD, S_END
  } state_t;

  state_t          r_state, w_next;
  logic [DW-1:0]   r_div;
  logic [5:0]      r_bit;
  logic [2:0]      r_nbyte;
  logic [7:0]      r_cmd_byte;
  logic            r_rnw;
  logic [55:0]     r_wdata;
  logic [55:0]     r_rdata;
  logic [7:0]      r_shift;
  logic            r_sio_out;
  logic            r_sio_oe;

  logic            w_accept;
  logic            w_div_end;
  logic            w_last_bit;
  logic            w_enter_lo;
  logic [5:0]      w_bit_n;
  logic            w_tx_bit;
  logic            w_rd_bit;
  logic [7:0]      w_byte;
  logic [2:0]      w_k;

  function automatic logic [2:0] f_nbyte(input logic [2:0] c);
    case (c)
      3'd1:    f_nbyte = 3'd1;
      3'd2:    f_nbyte = 3'd7;
      3'd3:    f_nbyte = 3'd3;
      3'd4:    f_nbyte = 3'd3;
      3'd5:    f_nbyte = 3'd2;
      default: f_nbyte = 3'd0;
    endcase
  endfunction

  // start is a one-cycle request with no ready: it is taken when the FSM is
  // idle, which includes the END (done) cycle so back-to-back transfers leave
  // chip-select low for exactly one cycle; otherwise it is dropped.
  assign w_accept   = start && (r_state == S_IDLE || r_state == S_END);
  assign w_div_end  = (r_div == DIV_LAST);
  assign w_last_bit = (r_bit == {r_nbyte, 3'b111});
  assign w_enter_lo = (w_next == S_BIT_LO) && (r_state != S_BIT_LO);
  assign w_bit_n    = (r_state == S_SETUP) ? 6'd0 : r_bit + 6'd1;
  assign w_tx_bit   = (w_bit_n < 6'd8) ? r_cmd_byte[~w_bit_n[2:0]]
                                       : r_wdata[w_bit_n - 6'd8];
  assign w_rd_bit   = r_rnw && (w_bit_n >= 6'd8);
  assign w_byte     = {sio_in, r_shift[7:1]};
  assign w_k        = r_bit[5:3] - 3'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETUP;
      S_SETUP:  if (w_div_end) w_next = S_BIT_LO;
      S_BIT_LO: if (w_div_end) w_next = S_BIT_HI;
      S_BIT_HI: if (w_div_end) w_next = w_last_bit ? S_HOLD : S_BIT_LO;
      S_HOLD:   if (w_div_end) w_next = S_END;
      S_END:    w_next = start ? S_SETUP : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_SETUP) || (r_state == S_BIT_LO) ||
                (r_state == S_BIT_HI) || (r_state == S_HOLD);
    rtc_cs    = busy;
    rtc_sck   = (r_state != S_BIT_LO);
    done      = (r_state == S_END);
    sio_out   = r_sio_out;
    sio_oe    = r_sio_oe;
    rdata     = r_rdata;
    dbg_state = r_state;
  end

  // Half-period counter reloads on every state change and never free-runs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               r_div <= '0;
    else if (w_next != r_state) r_div <= '0;
    else if (r_state != S_IDLE) r_div <= r_div + DW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bit      <= '0;
      r_nbyte    <= '0;
      r_cmd_byte <= '0;
      r_rnw      <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_shift    <= '0;
      r_sio_out  <= 1'b0;
      r_sio_oe   <= 1'b1;
    end else begin
      if (w_accept) begin
        r_cmd_byte <= {4'b0110, cmd, rnw};
        r_rnw      <= rnw;
        r_wdata    <= wdata;
        r_nbyte    <= f_nbyte(cmd);
        r_rdata    <= '0;
        r_bit      <= '0;
        r_sio_out  <= 1'b0;
        r_sio_oe   <= 1'b1;
      end
      if (w_enter_lo) begin
        r_bit     <= w_bit_n;
        r_sio_out <= w_rd_bit ? 1'b0 : w_tx_bit;
        r_sio_oe  <= !w_rd_bit;
      end
      // Read data is sampled on the last low cycle, just before sck rises.
      if (r_state == S_BIT_LO && w_div_end && r_rnw && r_bit >= 6'd8) begin
        r_shift <= w_byte;
        if (r_bit[2:0] == 3'd7) r_rdata[{w_k, 3'b000} +: 8] <= w_byte;
      end
      if (r_state == S_HOLD && w_next == S_END) begin
        r_sio_out <= 1'b0;
        r_sio_oe  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_s3511_host.sv
// Directed bench for s3511_host: three instances (CLK_DIV 4, 2, 1) share the
// bus inputs; a bus monitor records sck edges and plays the RTC read data.
module tb_s3511_host;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start4 = 1'b0, start2 = 1'b0, start1 = 1'b0;
  logic [2:0]  cmd = '0;
  logic        rnw = 1'b0;
  logic [55:0] wdata = '0;
  logic        sio_in = 1'b1;

  logic [55:0] rdata_4, rdata_2, rdata_1;
  logic        busy_4, busy_2, busy_1, done_4, done_2, done_1;
  logic        cs_4, cs_2, cs_1, sck_4, sck_2, sck_1;
  logic        out_4, out_2, out_1, oe_4, oe_2, oe_1;
  logic [2:0]  dbg_4, dbg_2, dbg_1;

  int checks = 0;
  int errors = 0;
  int sel = 4;

  logic [7:0]  model_bytes [7];
  logic        model_rnw = 1'b0;

  // monitor state
  logic        prev_sck = 1'b1, prev_cs = 1'b0;
  int          fall_cnt = 0, rise_cnt = 0, busy_cnt = 0, done_cnt = 0;
  int          low_cnt = 1000, last_gap = 1000;
  logic [63:0] rise_bits = '0, rise_oe = '0;

  s3511_host #(.CLK_DIV(4)) u_div4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .cmd(cmd), .rnw(rnw),
    .wdata(wdata), .rdata(rdata_4), .busy(busy_4), .done(done_4),
    .rtc_cs(cs_4), .rtc_sck(sck_4), .sio_out(out_4), .sio_oe(oe_4),
    .sio_in(sio_in), .dbg_state(dbg_4));
  s3511_host #(.CLK_DIV(2)) u_div2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .cmd(cmd), .rnw(rnw),
    .wdata(wdata), .rdata(rdata_2), .busy(busy_2), .done(done_2),
    .rtc_cs(cs_2), .rtc_sck(sck_2), .sio_out(out_2), .sio_oe(oe_2),
    .sio_in(sio_in), .dbg_state(dbg_2));
  s3511_host #(.CLK_DIV(1)) u_div1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .cmd(cmd), .rnw(rnw),
    .wdata(wdata), .rdata(rdata_1), .busy(busy_1), .done(done_1),
    .rtc_cs(cs_1), .rtc_sck(sck_1), .sio_out(out_1), .sio_oe(oe_1),
    .sio_in(sio_in), .dbg_state(dbg_1));

  logic [55:0] m_rdata;
  logic        m_busy, m_done, m_cs, m_sck, m_out, m_oe;
  assign m_rdata = (sel == 4) ? rdata_4 : (sel == 2) ? rdata_2 : rdata_1;
  assign m_busy  = (sel == 4) ? busy_4  : (sel == 2) ? busy_2  : busy_1;
  assign m_done  = (sel == 4) ? done_4  : (sel == 2) ? done_2  : done_1;
  assign m_cs    = (sel == 4) ? cs_4    : (sel == 2) ? cs_2    : cs_1;
  assign m_sck   = (sel == 4) ? sck_4   : (sel == 2) ? sck_2   : sck_1;
  assign m_out   = (sel == 4) ? out_4   : (sel == 2) ? out_2   : out_1;
  assign m_oe    = (sel == 4) ? oe_4    : (sel == 2) ? oe_2    : oe_1;

  // clock / reset
  always #5 clock = ~clock;

  // Bus monitor and RTC read-data model, sampled on the falling clock edge.
  always @(negedge clock) begin : monitor
    logic [7:0] t;
    int b;
    if (!prev_cs && m_cs) begin
      fall_cnt  <= 0;
      rise_cnt  <= 0;
      rise_bits <= '0;
      rise_oe   <= '0;
      busy_cnt  <= 1;
      done_cnt  <= 0;
      last_gap  <= low_cnt;
      low_cnt   <= 0;
    end else begin
      if (!m_cs) low_cnt <= low_cnt + 1;
      if (m_busy) busy_cnt <= busy_cnt + 1;
      if (m_done) done_cnt <= done_cnt + 1;
      if (prev_sck && !m_sck) begin
        b = fall_cnt - 8;
        if (fall_cnt >= 8 && model_rnw) begin
          t = model_bytes[b / 8];
          sio_in <= t[b % 8];
        end else begin
          sio_in <= 1'b1;
        end
        fall_cnt <= fall_cnt + 1;
      end
      if (!prev_sck && m_sck && m_cs) begin
        if (rise_cnt < 64) begin
          rise_bits[rise_cnt] <= m_out;
          rise_oe[rise_cnt]   <= m_oe;
        end
        rise_cnt <= rise_cnt + 1;
      end
    end
    prev_sck <= m_sck;
    prev_cs  <= m_cs;
  end

  // driver tasks
  task automatic do_start(input int which, input logic [2:0] c, input logic r,
                          input logic [55:0] wd);
    @(posedge clock); #1;
    cmd = c; rnw = r; wdata = wd; model_rnw = r;
    start4 = (which == 4); start2 = (which == 2); start1 = (which == 1);
    @(posedge clock); #1;
    start4 = 1'b0; start2 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      if (m_done === 1'b1) ok = 1'b1;
      else begin @(posedge clock); #1; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, want done", max_cyc);
    end
  endtask

  task automatic test_reset;
    sel = 4;
    checks++;
    if ({m_cs, m_sck, m_oe, m_out, m_busy, m_done} !== 6'b011000) begin
      errors++;
      $display("FAIL reset_pins: got %b want 011000", {m_cs, m_sck, m_oe, m_out, m_busy, m_done});
    end
    checks++;
    if (m_rdata !== 56'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0", m_rdata);
    end
  endtask

  task automatic test_status_write;
    sel = 4;
    do_start(4, 3'b001, 1'b0, 56'h40);
    wait_done(300);
    @(negedge clock); #1;
    checks++;
    if (rise_cnt !== 16) begin errors++; $display("FAIL sw_rises: got %0d want 16", rise_cnt); end
    checks++;
    if (rise_bits[15:0] !== 16'h4046) begin errors++; $display("FAIL sw_bits: got %h want 4046", rise_bits[15:0]); end
    checks++;
    if (rise_oe[15:0] !== 16'hFFFF) begin errors++; $display("FAIL sw_oe: got %h want ffff", rise_oe[15:0]); end
    checks++;
    if (busy_cnt !== 136) begin errors++; $display("FAIL sw_busy: got %0d want 136", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL sw_done: got %0d want 1", done_cnt); end
    @(posedge clock); #1;
    checks++;
    if ({m_cs, m_oe, m_out, m_done} !== 4'b0100) begin
      errors++;
      $display("FAIL sw_after_end: got %b want 0100", {m_cs, m_oe, m_out, m_done});
    end
  endtask

  task automatic test_reset_mid;
    bit hit;
    sel = 2;
    model_bytes = '{8'h20, 8'h05, 8'h17, 8'h03, 8'h14, 8'h30, 8'h45};
    do_start(2, 3'b010, 1'b1, 56'h0);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (m_rdata != 56'h0 && m_sck === 1'b0) hit = 1'b1;
      else begin @(posedge clock); #1; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_mid_reach: got no partial read, want one"); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({m_cs, m_sck, m_oe, m_busy, m_done} !== 5'b01100) begin
      errors++;
      $display("FAIL rst_mid_pins: got %b want 01100", {m_cs, m_sck, m_oe, m_busy, m_done});
    end
    checks++;
    if (m_rdata !== 56'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h want 0", m_rdata); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_datetime_read;
    sel = 2;
    model_bytes = '{8'h20, 8'h05, 8'h17, 8'h03, 8'h14, 8'h30, 8'h45};
    do_start(2, 3'b010, 1'b1, 56'hFF_FFFF_FFFF_FFFF);
    wait_done(1000);
    @(negedge clock); #1;
    checks++;
    if (rise_cnt !== 64) begin errors++; $display("FAIL dt_rises: got %0d want 64", rise_cnt); end
    checks++;
    if (rise_bits[7:0] !== 8'hA6) begin errors++; $display("FAIL dt_cmd: got %h want a6", rise_bits[7:0]); end
    checks++;
    if (rise_oe !== 64'h0000_0000_0000_00FF) begin errors++; $display("FAIL dt_oe: got %h want ff", rise_oe); end
    checks++;
    if (m_rdata !== 56'h45_30_14_03_17_05_20) begin
      errors++; $display("FAIL dt_rdata: got %h want 45301403170520", m_rdata);
    end
    checks++;
    if (busy_cnt !== 260) begin errors++; $display("FAIL dt_busy: got %0d want 260", busy_cnt); end
  endtask

  task automatic test_time_read;
    sel = 1;
    model_bytes = '{8'h12, 8'h34, 8'h56, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_start(1, 3'b011, 1'b1, 56'h0);
    wait_done(200);
    @(negedge clock); #1;
    checks++;
    if (rise_cnt !== 32) begin errors++; $display("FAIL tr_rises: got %0d want 32", rise_cnt); end
    checks++;
    if (rise_bits[7:0] !== 8'hE6) begin errors++; $display("FAIL tr_cmd: got %h want e6", rise_bits[7:0]); end
    checks++;
    if (m_rdata !== 56'h00_0000_0056_3412) begin errors++; $display("FAIL tr_rdata: got %h want 563412", m_rdata); end
    checks++;
    if (busy_cnt !== 66) begin errors++; $display("FAIL tr_busy: got %0d want 66", busy_cnt); end
  endtask

  task automatic test_reset_cmd;
    sel = 2;
    do_start(2, 3'b000, 1'b0, 56'hAA_AAAA_AAAA_AAAA);
    wait_done(200);
    @(negedge clock); #1;
    checks++;
    if (rise_cnt !== 8) begin errors++; $display("FAIL rc_rises: got %0d want 8", rise_cnt); end
    checks++;
    if (rise_bits[7:0] !== 8'h06) begin errors++; $display("FAIL rc_cmd: got %h want 06", rise_bits[7:0]); end
    checks++;
    if (busy_cnt !== 36) begin errors++; $display("FAIL rc_busy: got %0d want 36", busy_cnt); end
  endtask

  task automatic test_back_to_back;
    sel = 1;
    model_bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_start(1, 3'b001, 1'b1, 56'h0);
    repeat (10) begin @(posedge clock); #1; end
    cmd = 3'b010; rnw = 1'b0; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    wait_done(100);
    cmd = 3'b000; rnw = 1'b0; model_rnw = 1'b0; start1 = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (busy_cnt !== 34) begin errors++; $display("FAIL bb_busy: got %0d want 34", busy_cnt); end
    checks++;
    if (rise_cnt !== 16) begin errors++; $display("FAIL bb_rises: got %0d want 16", rise_cnt); end
    checks++;
    if (rise_bits[7:0] !== 8'hC6) begin errors++; $display("FAIL bb_cmd: got %h want c6", rise_bits[7:0]); end
    checks++;
    if (m_rdata !== 56'hA5) begin errors++; $display("FAIL bb_rdata: got %h want a5", m_rdata); end
    @(posedge clock); #1;
    start1 = 1'b0;
    checks++;
    if ({m_busy, m_cs} !== 2'b11) begin errors++; $display("FAIL bb_restart: got %b want 11", {m_busy, m_cs}); end
    checks++;
    if (m_rdata !== 56'h0) begin errors++; $display("FAIL bb_rdata_clr: got %h want 0", m_rdata); end
    @(negedge clock); #1;
    checks++;
    if (last_gap !== 1) begin errors++; $display("FAIL bb_gap: got %0d want 1", last_gap); end
    wait_done(100);
    @(negedge clock); #1;
    checks++;
    if (rise_cnt !== 8) begin errors++; $display("FAIL bb2_rises: got %0d want 8", rise_cnt); end
    checks++;
    if (rise_bits[7:0] !== 8'h06) begin errors++; $display("FAIL bb2_cmd: got %h want 06", rise_bits[7:0]); end
    checks++;
    if (busy_cnt !== 18) begin errors++; $display("FAIL bb2_busy: got %0d want 18", busy_cnt); end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_reset;
    test_status_write;
    test_reset_mid;
    test_datetime_read;
    test_time_read;
    test_reset_cmd;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
